// File: rtl/pci_initiator.sv
// rtl/pci_initiator.sv - PCI bus master for single-word and burst memory reads/writes
//
// Purpose: takes a local request, arbitrates for the bus, runs the address phase
// and up to MAX_LEN data phases on the shared AD bus, handles master abort,
// target disconnect and target abort, and reports the outcome with done/status.
//
// Ports:
//   clk, rest                  bus clock, synchronous active-high reset
//   req_start/cmd/addr/len/be  local request (len clamped to MAX_LEN, len=0 ignored)
//   wr_data, word_idx          local write word for the current data phase
//   rd_data, rd_valid, rd_idx  registered read word and its index
//   wr_ack                     write word word_idx completes this cycle
//   busy, done, status, xfer_cnt  transaction progress and result
//   req_n, gnt_n               arbitration
//   frame, irdy, cbe, ad       bus signals, tri-stated unless this master owns the bus
//   trdy, devsel, stop         target responses, active low
module pci_initiator #(
  parameter int MAX_LEN        = 4,
  parameter int DEVSEL_TIMEOUT = 5
) (
  input  logic        clk,
  input  logic        rest,
  input  logic        req_start,
  input  logic [3:0]  req_cmd,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_len,
  input  logic [3:0]  req_be,
  input  logic [31:0] wr_data,
  output logic [1:0]  word_idx,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic [1:0]  rd_idx,
  output logic        wr_ack,
  output logic        busy,
  output logic        done,
  output logic [1:0]  status,
  output logic [2:0]  xfer_cnt,
  output logic        req_n,
  input  logic        gnt_n,
  inout  logic        frame,
  inout  logic        irdy,
  output logic [3:0]  cbe,
  inout  logic [31:0] ad,
  input  logic        trdy,
  input  logic        devsel,
  input  logic        stop
);

  localparam int CW = $clog2(DEVSEL_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_ADDR,
    S_DATA,
    S_TERM,
    S_RELEASE
  } state_t;

  state_t        state, state_next;
  logic [3:0]    cmd_q;
  logic [31:0]   addr_q;
  logic [3:0]    be_q;
  logic [2:0]    remaining;
  logic [CW-1:0] devsel_cnt;
  logic [CW-1:0] cnt_plus;
  logic          devsel_seen;

  logic          take;
  logic          xfer;
  logic          cnt_step;
  logic          go_term;
  logic [1:0]    term_code;
  logic [2:0]    len_clamped;
  logic          is_write;

  logic          own_bus;
  logic          frame_val, irdy_val, ad_oe;
  logic [3:0]    cbe_val;
  logic [31:0]   ad_val;

  // Memory write commands have bit 0 set; memory read has it clear.
  assign is_write    = cmd_q[0];
  assign len_clamped = (req_len > 3'(MAX_LEN)) ? 3'(MAX_LEN) : req_len;
  assign cnt_plus    = devsel_cnt + CW'(1);

  always_ff @(posedge clk) begin
    if (rest) begin
      state       <= S_IDLE;
      cmd_q       <= 4'h0;
      addr_q      <= 32'h0;
      be_q        <= 4'h0;
      remaining   <= 3'd0;
      word_idx    <= 2'd0;
      xfer_cnt    <= 3'd0;
      status      <= 2'b00;
      rd_data     <= 32'h0;
      rd_valid    <= 1'b0;
      rd_idx      <= 2'd0;
      devsel_cnt  <= '0;
      devsel_seen <= 1'b0;
    end else begin
      state    <= state_next;
      rd_valid <= 1'b0;
      if (take) begin
        cmd_q     <= req_cmd;
        addr_q    <= req_addr;
        be_q      <= req_be;
        remaining <= len_clamped;
        word_idx  <= 2'd0;
        xfer_cnt  <= 3'd0;
        status    <= 2'b00;
      end
      if (state == S_ADDR) begin
        devsel_cnt  <= '0;
        devsel_seen <= 1'b0;
      end
      if (cnt_step) devsel_cnt <= cnt_plus;
      if (state == S_DATA && !devsel) devsel_seen <= 1'b1;
      if (xfer) begin
        remaining <= remaining - 3'd1;
        word_idx  <= word_idx + 2'd1;
        xfer_cnt  <= xfer_cnt + 3'd1;
        if (!is_write) begin
          rd_data  <= ad;
          rd_valid <= 1'b1;
          rd_idx   <= word_idx;
        end
      end
      if (go_term) status <= term_code;
    end
  end

  always_comb begin
    state_next = state;
    take       = 1'b0;
    xfer       = 1'b0;
    cnt_step   = 1'b0;
    go_term    = 1'b0;
    term_code  = 2'b00;
    case (state)
      S_IDLE: begin
        if (req_start && req_len != 3'd0) begin
          take       = 1'b1;
          state_next = S_ARB;
        end
      end
      S_ARB: begin
        // Only take the bus once the previous owner has fully finished.
        if (!gnt_n && frame && irdy) state_next = S_ADDR;
      end
      S_ADDR: state_next = S_DATA;
      S_DATA: begin
        if (devsel) begin
          if (!devsel_seen) begin
            cnt_step = 1'b1;
            // The address cycle is clock 0, so the last data edge before
            // TERM is clock DEVSEL_TIMEOUT-1 and TERM lands on DEVSEL_TIMEOUT.
            if (cnt_plus == CW'(DEVSEL_TIMEOUT - 1)) begin
              go_term   = 1'b1;
              term_code = 2'b10;
            end
          end else if (!stop) begin
            go_term   = 1'b1;
            term_code = 2'b11;
          end
        end else begin
          xfer = !trdy;
          if (!trdy && remaining == 3'd1) begin
            go_term   = 1'b1;
            term_code = 2'b00;
          end else if (!stop) begin
            go_term   = 1'b1;
            term_code = 2'b01;
          end
        end
        if (go_term) state_next = S_TERM;
      end
      S_TERM:    state_next = S_RELEASE;
      S_RELEASE: state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    own_bus   = (state == S_ADDR) || (state == S_DATA) || (state == S_TERM);
    frame_val = 1'b1;
    irdy_val  = 1'b1;
    cbe_val   = 4'hF;
    ad_oe     = 1'b0;
    ad_val    = wr_data;
    case (state)
      S_ADDR: begin
        frame_val = 1'b0;
        cbe_val   = cmd_q;
        ad_oe     = 1'b1;
        ad_val    = addr_q;
      end
      S_DATA: begin
        // FRAME goes high in the final data phase of the burst.
        frame_val = (remaining == 3'd1);
        irdy_val  = 1'b0;
        cbe_val   = be_q;
        // Reads leave AD floating so the first data cycle is the turnaround.
        ad_oe     = is_write;
      end
      default: ;
    endcase
  end

  assign busy   = (state == S_ARB) || own_bus;
  assign done   = (state == S_TERM);
  assign req_n  = (state != S_ARB);
  assign wr_ack = xfer && is_write;

  assign frame = own_bus ? frame_val : 1'bz;
  assign irdy  = own_bus ? irdy_val  : 1'bz;
  assign cbe   = own_bus ? cbe_val   : 4'bzzzz;
  assign ad    = ad_oe   ? ad_val    : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_pci_initiator.sv
// tb/tb_pci_initiator.sv - testbench for pci_initiator
module tb_pci_initiator;

  logic        clk = 1'b0;
  logic        rest;
  logic        req_start;
  logic [3:0]  req_cmd;
  logic [31:0] req_addr;
  logic [2:0]  req_len;
  logic [3:0]  req_be;
  logic [31:0] wr_data;
  logic [1:0]  word_idx;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [1:0]  rd_idx;
  logic        wr_ack, busy, done;
  logic [1:0]  status;
  logic [2:0]  xfer_cnt;
  logic        req_n, gnt_n;
  logic        trdy, devsel, stop;

  // Released lines float high on frame/irdy/ad and low on cbe, so a
  // released cbe is distinguishable from the TERM value 1111.
  tri1         frame, irdy;
  tri1 [31:0]  ad;
  tri0 [3:0]   cbe;

  logic        fm_frame_en, fm_irdy_en;
  logic        tgt_ad_en;
  logic [31:0] tgt_ad;
  logic [31:0] wbase;

  assign frame   = fm_frame_en ? 1'b0 : 1'bz;
  assign irdy    = fm_irdy_en  ? 1'b0 : 1'bz;
  assign ad      = tgt_ad_en   ? tgt_ad : 32'hzzzz_zzzz;
  assign wr_data = wbase + {30'd0, word_idx};

  always #5 clk = ~clk;

  pci_initiator #(.MAX_LEN(4), .DEVSEL_TIMEOUT(5)) dut (
    .clk(clk), .rest(rest), .req_start(req_start), .req_cmd(req_cmd),
    .req_addr(req_addr), .req_len(req_len), .req_be(req_be), .wr_data(wr_data),
    .word_idx(word_idx), .rd_data(rd_data), .rd_valid(rd_valid), .rd_idx(rd_idx),
    .wr_ack(wr_ack), .busy(busy), .done(done), .status(status), .xfer_cnt(xfer_cnt),
    .req_n(req_n), .gnt_n(gnt_n), .frame(frame), .irdy(irdy), .cbe(cbe), .ad(ad),
    .trdy(trdy), .devsel(devsel), .stop(stop)
  );

  // Target behaviour per data cycle k: DEVSEL low for dev_lat <= k < abort_at,
  // TRDY low from trdy_from while DEVSEL is low, STOP low at stop_at/abort_at.
  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] addr;
    logic [2:0]  len;
    logic [3:0]  be;
    logic [31:0] wb;
    int          dev_lat;
    int          trdy_from;
    int          stop_at;
    int          abort_at;
    logic [1:0]  exp_status;
    logic [2:0]  exp_xfer;
    int          exp_cycles;
  } vec_t;

  vec_t vecs[8];
  vec_t hv;
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic bus_idle();
    devsel    = 1'b1;
    trdy      = 1'b1;
    stop      = 1'b1;
    tgt_ad_en = 1'b0;
  endtask

  task automatic start_req(input vec_t v);
    @(negedge clk);
    req_cmd   = v.cmd;
    req_addr  = v.addr;
    req_len   = v.len;
    req_be    = v.be;
    wbase     = v.wb;
    req_start = 1'b1;
    @(negedge clk);
    req_start = 1'b0;
    chk("arb_busy", busy, 1);
    chk("arb_req_n", req_n, 0);
  endtask

  task automatic arb_addr(input vec_t v);
    bit ok = 0;
    gnt_n = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (frame == 1'b0) ok = 1;
    end
    chk("addr_seen", ok, 1);
    chk("addr_ad", ad, v.addr);
    chk("addr_cbe", cbe, v.cmd);
    chk("addr_irdy", irdy, 1);
    chk("addr_req_n", req_n, 1);
    gnt_n = 1'b1;
  endtask

  task automatic data_phase(input vec_t v);
    int   k = 0, words = 0, acks = 0, vals = 0, len_eff;
    bit   fin = 0, is_wr;
    logic dv, tr, sp, xf;
    len_eff = (v.len > 3'd4) ? 4 : int'(v.len);
    is_wr   = v.cmd[0];
    while (!fin && k < 40) begin
      @(negedge clk);
      if (rd_valid) begin
        chk("rd_idx", rd_idx, vals);
        chk("rd_data", rd_data, 32'h11111111 * (vals + 1));
        vals++;
      end
      if (done) begin
        bus_idle();
        #1;
        chk("term_status", status, v.exp_status);
        chk("term_xfer_cnt", xfer_cnt, v.exp_xfer);
        chk("data_cycles", k, v.exp_cycles);
        chk("term_frame", frame, 1);
        chk("term_irdy", irdy, 1);
        chk("term_cbe", cbe, 4'hF);
        chk("term_ad", ad, 32'hFFFFFFFF);
        fin = 1;
      end else begin
        dv = !(k >= v.dev_lat && k < v.abort_at);
        sp = !(k == v.stop_at || k == v.abort_at);
        tr = !(!dv && k >= v.trdy_from);
        devsel    = dv;
        stop      = sp;
        trdy      = tr;
        tgt_ad_en = !is_wr && !tr;
        tgt_ad    = 32'h11111111 * (words + 1);
        #1;
        xf = !dv && !tr;
        chk("data_frame", frame, (len_eff - words == 1) ? 1 : 0);
        chk("data_irdy", irdy, 0);
        chk("data_cbe", cbe, v.be);
        if (is_wr) begin
          chk("wr_ad", ad, v.wb + words);
          chk("wr_ack", wr_ack, xf);
          if (wr_ack) begin
            chk("wr_ack_idx", word_idx, words % 4);
            acks++;
          end
        end else begin
          chk("rd_no_ack", wr_ack, 0);
          if (tr) chk("rd_ad_released", ad, 32'hFFFFFFFF);
        end
        if (xf) words++;
        k++;
      end
    end
    chk("done_seen", fin, 1);
    @(negedge clk);
    chk("rel_busy", busy, 0);
    chk("rel_done", done, 0);
    chk("rel_cbe", cbe, 4'h0);
    chk("rel_ad", ad, 32'hFFFFFFFF);
    chk("words_reported", is_wr ? acks : vals, v.exp_xfer);
  endtask

  initial begin
    // cmd, addr, len, be, wbase, dev_lat, trdy_from, stop_at, abort_at, status, xfer, cycles
    vecs[0] = '{4'b0111, 32'hFFFF0004, 3'd1, 4'b0000, 32'hA5A5A5A5, 0, 0, 99, 99, 2'b00, 3'd1, 1};
    vecs[1] = '{4'b0110, 32'hFFFF0000, 3'd4, 4'b0011, 32'h00000000, 0, 1, 99, 99, 2'b00, 3'd4, 5};
    vecs[2] = '{4'b0110, 32'h12345678, 3'd2, 4'b0000, 32'h00000000, 99, 0, 99, 99, 2'b10, 3'd0, 4};
    vecs[3] = '{4'b0111, 32'hFFFF0000, 3'd4, 4'b0000, 32'hC0DE0000, 0, 0, 1, 99, 2'b01, 3'd2, 2};
    vecs[4] = '{4'b0111, 32'hFFFF0000, 3'd7, 4'b1100, 32'h5A000010, 2, 2, 99, 99, 2'b00, 3'd4, 6};
    vecs[5] = '{4'b0110, 32'hFFFF0000, 3'd3, 4'b0000, 32'h00000000, 0, 1, 99, 2, 2'b11, 3'd1, 3};
    vecs[6] = '{4'b0110, 32'hFFFF0004, 3'd2, 4'b0000, 32'h00000000, 0, 99, 1, 99, 2'b01, 3'd0, 2};
    vecs[7] = '{4'b0111, 32'hFFFF0008, 3'd2, 4'b0001, 32'h0BAD0000, 0, 0, 1, 99, 2'b00, 3'd2, 2};

    rest = 1'b1; req_start = 1'b0; req_cmd = 4'h0; req_addr = 32'h0; req_len = 3'd0;
    req_be = 4'h0; wbase = 32'h0; gnt_n = 1'b1; fm_frame_en = 1'b0; fm_irdy_en = 1'b0;
    tgt_ad = 32'h0;
    bus_idle();
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_req_n", req_n, 1);
    chk("rst_done", done, 0);
    chk("rst_status", status, 0);
    chk("rst_xfer_cnt", xfer_cnt, 0);
    chk("rst_word_idx", word_idx, 0);
    chk("rst_cbe", cbe, 4'h0);
    chk("rst_ad", ad, 32'hFFFFFFFF);
    rest = 1'b0;

    // A zero-length request must be ignored.
    @(negedge clk);
    req_len = 3'd0; req_start = 1'b1;
    @(negedge clk);
    req_start = 1'b0;
    chk("len0_busy", busy, 0);
    chk("len0_req_n", req_n, 1);

    for (int i = 0; i < 8; i++) begin
      start_req(vecs[i]);
      arb_addr(vecs[i]);
      data_phase(vecs[i]);
    end

    // Foreign master still owns the bus while GNT_N is already low.
    hv = '{4'b0110, 32'hFFFF0008, 3'd1, 4'b0000, 32'h00000000, 0, 1, 99, 99, 2'b00, 3'd1, 2};
    start_req(hv);
    fm_frame_en = 1'b1; fm_irdy_en = 1'b1; gnt_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fm_req_n", req_n, 0);
      chk("fm_cbe_released", cbe, 4'h0);
    end
    fm_frame_en = 1'b0;
    @(negedge clk);
    chk("fm_irdy_hold_req_n", req_n, 0);
    chk("fm_irdy_hold_cbe", cbe, 4'h0);
    fm_irdy_en = 1'b0;
    arb_addr(hv);
    data_phase(hv);

    // Reset in the middle of a 4-word read.
    hv = '{4'b0110, 32'hFFFF0000, 3'd4, 4'b0000, 32'h00000000, 0, 1, 99, 99, 2'b00, 3'd0, 0};
    start_req(hv);
    arb_addr(hv);
    @(negedge clk);
    devsel = 1'b0;
    @(negedge clk);
    trdy = 1'b0; tgt_ad = 32'h11111111; tgt_ad_en = 1'b1;
    @(negedge clk);
    chk("pre_rst_frame", frame, 0);
    rest = 1'b1;
    bus_idle();
    @(negedge clk);
    chk("mid_rst_frame", frame, 1);
    chk("mid_rst_irdy", irdy, 1);
    chk("mid_rst_cbe", cbe, 4'h0);
    chk("mid_rst_ad", ad, 32'hFFFFFFFF);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_rd_valid", rd_valid, 0);
    chk("mid_rst_xfer_cnt", xfer_cnt, 0);
    chk("mid_rst_word_idx", word_idx, 0);
    rest = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_no_done", done, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pci_initiator.md
Name: pci_initiator

Overview:
- PCI bus master that issues single-word and burst memory read/write transactions on the shared 32-bit AD bus.
- Provides the initiator side for targets such as the 4-word device at 0xFFFF0000.
- A local request port starts a transaction. The block arbitrates via REQ_N/GNT_N, then runs the address and data phases.
- It handles DEVSEL timeout (master abort), target disconnect and target abort, then reports the result on a DONE/STATUS port.

Parameters:
MAX_LEN, 4, maximum words per burst; REQ_LEN above this is clamped.
DEVSEL_TIMEOUT, 5, clocks after the address phase without DEVSEL low before master abort.

Ports:
CLK  input  1  bus clock; all logic on posedge.
REST  input  1  reset; synchronous, active-high.
REQ_START  input  1  one-cycle request pulse; ignored while BUSY=1 or REQ_LEN=0.
REQ_CMD  input  4  bus command; 0110 = memory read, 0111 = memory write.
REQ_ADDR  input  32  start address, driven on AD unchanged.
REQ_LEN  input  3  word count, 1..MAX_LEN.
REQ_BE  input  4  active-low byte enables for all data phases.
WR_DATA  input  32  write word for WORD_IDX; local side supplies it combinationally.
WORD_IDX  output  2  index of the current data phase word.
RD_DATA  output  32  registered read word.
RD_VALID  output  1  one-cycle pulse; RD_DATA holds word RD_IDX.
RD_IDX  output  2  index of RD_DATA.
WR_ACK  output  1  one-cycle pulse when write word WORD_IDX completes.
BUSY  output  1  high from accepted REQ_START until DONE.
DONE  output  1  one-cycle completion pulse.
STATUS  output  2  valid with DONE: 00 all words, 01 target disconnect, 10 master abort, 11 target abort.
XFER_CNT  output  3  words transferred, valid with DONE.
REQ_N  output  1  bus request, active low.
GNT_N  input  1  bus grant, active low.
FRAME  inout  1  driven only while owning the bus, else Z.
IRDY  inout  1  driven only while owning the bus, else Z.
CBE  output  4  driven only while owning the bus, else Z.
AD  inout  32  address and data.
TRDY, DEVSEL, STOP  input  1  target responses, active low.

Behaviour:
- REST=1 at posedge gives next state:
  - FSM in IDLE.
  - REQ_N=1, BUSY=0, DONE=0, RD_VALID=0, WR_ACK=0, STATUS=00, XFER_CNT=0, WORD_IDX=0.
  - FRAME, IRDY, CBE and AD all Z.
  - Mid-transaction reset releases the bus at that edge, with no orderly termination.
- IDLE:
  - On an accepted REQ_START, latch CMD, ADDR, BE and clamped LEN.
  - Set BUSY=1, REQ_N=0, go to ARB.
- ARB:
  - Go to ADDR when GNT_N=0, FRAME=1 and IRDY=1 are all sampled at the same edge.
  - Otherwise wait indefinitely.
- ADDR (1 cycle):
  - Drive FRAME=0, IRDY=1, AD=ADDR, CBE=CMD.
  - Set REQ_N=1, clear the DEVSEL counter, go to DATA.
  - GNT_N is ignored from here on.
- DATA:
  - Drive IRDY=0 and CBE=BE.
  - Write: AD=WR_DATA. Read: AD=Z, so the first DATA cycle is the turnaround.
  - FRAME=1 in the data phase where remaining words = 1, else 0.
- Per edge in DATA, in priority order:
  - DEVSEL=1: increment the counter. At DEVSEL_TIMEOUT, record STATUS=10 and go to TERM.
  - DEVSEL=1 and STOP=0 after DEVSEL was seen low: target abort, STATUS=11, go to TERM.
  - TRDY=0: word transfers. Read: capture AD into RD_DATA, pulse RD_VALID. Write: pulse WR_ACK. Then increment WORD_IDX and XFER_CNT.
  - Remaining words reach 0: STATUS=00, go to TERM.
  - STOP=0 with remaining words > 0: STATUS=01, go to TERM. This applies with TRDY=0 (disconnect with data) or TRDY=1 (without data).
- TERM (1 cycle):
  - Drive FRAME=1, IRDY=1, AD=Z (write), CBE=1111.
  - Pulse DONE; STATUS and XFER_CNT are valid in this cycle.
  - Go to RELEASE.
- RELEASE (1 cycle): all bus outputs Z, BUSY=0, go to IDLE. A new REQ_START is accepted the following cycle.
- WORD_IDX wraps modulo 4. The address is never incremented on the bus; the target owns linear increment.
- AD is never driven in the cycle after read data is sampled. Write data changes only on edges where TRDY=0.

Test Plan:
1. Write, CMD=0111, ADDR=FFFF0004, LEN=1, BE=0000, WR_DATA=A5A5A5A5; fast DEVSEL/TRDY one cycle after ADDR -> FRAME high in first DATA cycle, one WR_ACK, DONE with STATUS=00, XFER_CNT=1.
2. Burst read, CMD=0110, ADDR=FFFF0000, LEN=4; target returns 11,22,33,44 with TRDY low from the 2nd DATA cycle -> four RD_VALID with RD_IDX 0..3 and matching data, AD Z throughout DATA, STATUS=00, XFER_CNT=4.
3. Read at 12345678, DEVSEL held high -> FRAME high and DONE 5 clocks after ADDR, STATUS=10, XFER_CNT=0.
4. Write LEN=4; target asserts STOP=0 with TRDY=0 on word 2 -> two WR_ACK, STATUS=01, XFER_CNT=2, then FRAME/IRDY high for one cycle, then Z.
5. GNT_N=0 while a foreign master holds FRAME=0 -> stays in ARB with REQ_N=0; ADDR is driven only after FRAME=1 and IRDY=1 are sampled.
6. REST=1 during DATA of a 4-word read -> next edge: FRAME/IRDY/AD/CBE Z, BUSY=0, no DONE pulse.
